dac_stream_tx: RTL and testbench



---
 rtl/dac_stream_pkg.sv | 12 +
 rtl/dac_stream_tx_if.sv | 12 +
 rtl/tx_sample_fifo.sv | 60 ++++++
 rtl/dac_stream_tx.sv | 134 +++++++++++++
 tb/tb_dac_stream_tx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dac_stream_pkg.sv
// rtl/dac_stream_pkg.sv - shared constants and types for the I2S DAC output stage
package dac_stream_pkg;

    localparam int FRAME_SLOTS     = 32;
    localparam int LEFT_SLOTS      = 16;
    localparam int MIN_HALF_PERIOD = 2;
    localparam int LOAD_SLOT       = 1;
    localparam int LR_SWITCH_SLOT  = 16;

    typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/dac_stream_tx_if.sv
// rtl/dac_stream_tx_if.sv - sample handshake between the ANC core and the DAC output stage
interface dac_stream_tx_if;
    import dac_stream_pkg::*;

    logic    sample_vld;
    sample_t sample;
    logic    sample_rdy;

    modport master (output sample_vld, output sample, input sample_rdy);
    modport slave  (input sample_vld, input sample, output sample_rdy);

endinterface

// File: rtl/tx_sample_fifo.sv
// rtl/tx_sample_fifo.sv - synchronous FIFO with wrap-bit pointers and occupancy output
module tx_sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Pointers share the index bits; the extra top bit tells full from empty.
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign level   = wptr_q - rptr_q;
    assign rd_data = mem_q[rptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = din;
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dac_stream_tx.sv
// rtl/dac_stream_tx.sv - buffers ANC samples and serialises them as I2S stereo frames
module dac_stream_tx
    import dac_stream_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PERIOD_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    dac_stream_tx_if.slave                smp,
    input  logic [PERIOD_W-1:0]           bclk_period,
    output logic                          bclk,
    output logic                          lr_clk,
    output logic                          dout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic                          overflow
);
    localparam int SLOT_W = $clog2(FRAME_SLOTS);
    localparam int SR_W   = 2 * DATA_W;

    logic [PERIOD_W-1:0] hp;
    logic                hp_wrap;
    logic [PERIOD_W-1:0] hp_cnt_q, hp_cnt_d;
    logic                bclk_q, bclk_d;
    logic                lr_clk_q, lr_clk_d;
    logic                dout_q, dout_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SR_W-1:0]     shift_q, shift_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic                started_q, started_d;
    logic                underflow_q, underflow_d;
    logic                overflow_q, overflow_d;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_word;

    tx_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (smp.sample_vld),
        .din     (smp.sample),
        .pop     (fifo_pop),
        .rd_data (fifo_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign smp.sample_rdy = ~fifo_full;

    // >= rather than == so that shrinking the period mid-count wraps at once.
    assign hp      = (bclk_period < PERIOD_W'(MIN_HALF_PERIOD)) ? PERIOD_W'(MIN_HALF_PERIOD) : bclk_period;
    assign hp_wrap = (hp_cnt_q >= hp - PERIOD_W'(1));

    always_comb begin
        hp_cnt_d    = hp_cnt_q + PERIOD_W'(1);
        bclk_d      = bclk_q;
        lr_clk_d    = lr_clk_q;
        dout_d      = dout_q;
        slot_d      = slot_q;
        shift_d     = shift_q;
        last_d      = last_q;
        started_d   = started_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q || (smp.sample_vld && fifo_full);
        fifo_pop    = 1'b0;

        if (hp_wrap) begin
            hp_cnt_d = '0;
            bclk_d   = ~bclk_q;
        end

        // Everything frame-related moves on the bclk falling toggle.
        if (hp_wrap && bclk_q) begin
            slot_d   = slot_q + SLOT_W'(1);
            lr_clk_d = (slot_d >= SLOT_W'(LR_SWITCH_SLOT));
            if (slot_d == SLOT_W'(LOAD_SLOT)) begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = {fifo_word, fifo_word};
                    last_d    = fifo_word;
                    started_d = 1'b1;
                end else if (started_q) begin
                    shift_d     = {last_q, last_q};
                    underflow_d = 1'b1;
                end else begin
                    shift_d = '0;
                end
            end else begin
                shift_d = {shift_q[SR_W-2:0], 1'b0};
            end
            dout_d = shift_d[SR_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hp_cnt_q    <= '0;
            bclk_q      <= 1'b0;
            lr_clk_q    <= 1'b0;
            dout_q      <= 1'b0;
            slot_q      <= '0;
            shift_q     <= '0;
            last_q      <= '0;
            started_q   <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            hp_cnt_q    <= hp_cnt_d;
            bclk_q      <= bclk_d;
            lr_clk_q    <= lr_clk_d;
            dout_q      <= dout_d;
            slot_q      <= slot_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            started_q   <= started_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bclk      = bclk_q;
    assign lr_clk    = lr_clk_q;
    assign dout      = dout_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dac_stream_tx.sv
// tb/tb_dac_stream_tx.sv - scoreboard bench decoding I2S frames from dac_stream_tx
module tb_dac_stream_tx;
    import dac_stream_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bclk_period;
    wire        bclk, lr_clk, dout, underflow, overflow;
    wire  [2:0] fifo_level;

    dac_stream_tx_if smp_if ();

    dac_stream_tx #(
        .DATA_W     (16),
        .FIFO_DEPTH (4),
        .PERIOD_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .smp         (smp_if.slave),
        .bclk_period (bclk_period),
        .bclk        (bclk),
        .lr_clk      (lr_clk),
        .dout        (dout),
        .fifo_level  (fifo_level),
        .underflow   (underflow),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Frame decoder: one bit per bclk rise, slots counted from reset.
    int          mslot;
    logic        prev_bclk, have_word, started_m, uf_exp;
    logic [15:0] cur_word, left_acc, right_acc;

    always @(negedge clk) begin
        if (rst) begin
            mslot     = 31;
            prev_bclk = 1'b0;
            have_word = 1'b0;
            started_m = 1'b0;
            uf_exp    = 1'b0;
            cur_word  = '0;
            left_acc  = '0;
            right_acc = '0;
            exp_q.delete();
        end else begin
            if (bclk && !prev_bclk) begin
                mslot = (mslot + 1) % 32;
                check("lr_clk_slot", {31'd0, lr_clk}, {31'd0, (mslot >= 16)});
                if (mslot == 1) begin
                    if (exp_q.size() > 0) begin
                        cur_word  = exp_q.pop_front();
                        started_m = 1'b1;
                    end else if (started_m) begin
                        uf_exp = 1'b1;
                    end
                    have_word = 1'b1;
                    check("underflow_flag", {31'd0, underflow}, {31'd0, uf_exp});
                end
                if (mslot >= 1 && mslot <= 16) left_acc = {left_acc[14:0], dout};
                if (mslot == 16) check("left_word", {16'd0, left_acc}, {16'd0, cur_word});
                if (mslot >= 17 || mslot == 0) right_acc = {right_acc[14:0], dout};
                if (mslot == 0 && have_word) check("right_word", {16'd0, right_acc}, {16'd0, cur_word});
            end
            prev_bclk = bclk;
        end
    end

    task automatic wait_lr_rise(output int n);
        logic p;
        logic done;
        p    = lr_clk;
        done = 1'b0;
        n    = 0;
        while (!done && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
            done = !p && lr_clk;
            p    = lr_clk;
        end
        if (!done) check("lr_rise_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_toggle(output int n);
        logic b0;
        b0 = bclk;
        n  = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bclk == b0 && n < 200);
        if (bclk == b0) check("bclk_toggle_timeout", 32'd0, 32'd1);
    endtask

    task automatic bclk_meas(output int per);
        int k;
        wait_toggle(k);
        if (bclk != 1'b1) wait_toggle(k);
        wait_toggle(k);
        per = k;
        wait_toggle(k);
        per += k;
    endtask

    task automatic push(input logic [15:0] s, input logic acc);
        smp_if.sample_vld = 1'b1;
        smp_if.sample     = s;
        check("sample_rdy", {31'd0, smp_if.sample_rdy}, {31'd0, acc});
        if (acc) exp_q.push_back(s);
        @(posedge clk);
        #1;
        smp_if.sample_vld = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bclk"},       {31'd0, bclk},              32'd0);
        check({tag, "_lr_clk"},     {31'd0, lr_clk},            32'd0);
        check({tag, "_dout"},       {31'd0, dout},              32'd0);
        check({tag, "_fifo_level"}, {29'd0, fifo_level},        32'd0);
        check({tag, "_sample_rdy"}, {31'd0, smp_if.sample_rdy}, 32'd1);
        check({tag, "_underflow"},  {31'd0, underflow},         32'd0);
        check({tag, "_overflow"},   {31'd0, overflow},          32'd0);
    endtask

    logic [15:0] burst [6];

    initial begin
        int n;
        burst = '{16'h8001, 16'h7FFE, 16'h0F0F, 16'hF0F0, 16'h1234, 16'h5678};
        rst               = 1'b1;
        bclk_period       = 8'd2;
        smp_if.sample_vld = 1'b0;
        smp_if.sample     = '0;
        @(posedge clk);
        #1;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle timing at the minimum half-period.
        bclk_meas(n);
        check("bclk_period_hp2", n, 32'd4);
        wait_lr_rise(n);
        wait_lr_rise(n);
        check("lr_period_hp2", n, 32'd128);
        repeat (3) wait_lr_rise(n);

        // Single word, then underflow repeats it.
        push(16'hA5C3, 1'b1);
        repeat (3) wait_lr_rise(n);
        check("underflow_sticky", {31'd0, underflow}, 32'd1);

        // Burst of six into a four-deep FIFO.
        bclk_period = 8'd8;
        wait_lr_rise(n);
        for (int i = 0; i < 6; i++) push(burst[i], i < 4);
        check("burst_overflow",   {31'd0, overflow},          32'd1);
        check("burst_fifo_level", {29'd0, fifo_level},        32'd4);
        check("burst_rdy_low",    {31'd0, smp_if.sample_rdy}, 32'd0);
        repeat (6) wait_lr_rise(n);

        // Period values below the minimum clamp to 2.
        bclk_period = 8'd0;
        bclk_meas(n);
        check("bclk_period_0", n, 32'd4);
        bclk_period = 8'd1;
        bclk_meas(n);
        check("bclk_period_1", n, 32'd4);

        // Shrink the period while the counter sits at 10.
        bclk_period = 8'd20;
        wait_toggle(n);
        wait_toggle(n);
        check("hp20_interval", n, 32'd20);
        repeat (10) @(posedge clk);
        #1;
        bclk_period = 8'd3;
        wait_toggle(n);
        check("shrink_wrap_next", n, 32'd1);
        wait_toggle(n);
        check("hp3_first", n, 32'd3);
        wait_toggle(n);
        check("hp3_second", n, 32'd3);

        // Reset mid-frame with two samples queued.
        wait_lr_rise(n);
        push(16'hCAFE, 1'b1);
        push(16'hBEEF, 1'b1);
        check("queued_level", {29'd0, fifo_level}, 32'd2);
        for (int k = 0; k < 8; k++) wait_toggle(n);
        check("slot20_lr", {31'd0, lr_clk}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("midframe_reset");
        rst = 1'b0;

        repeat (2) wait_lr_rise(n);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
